// File: rtl/wb_uart_tx_if.sv
// Wishbone B3 classic bus bundle for wb_uart_tx; signal names follow the slave's view.
// Single cycle per access: the master holds cyc/stb until ack_o, and the slave answers with a one-cycle ack.
interface wb_uart_tx_if #(
  parameter int ADDR_WIDTH = 31,
  parameter int DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0] addr_i;
  logic [DATA_WIDTH-1:0] data_i;
  logic [DATA_WIDTH-1:0] data_o;
  logic                  cyc_i;
  logic [3:0]            sel_i;
  logic                  stb_i;
  logic                  we_i;
  logic                  ack_o;
  logic                  err_o;
  logic                  rty_o;

  modport master (
    output addr_i, data_i, cyc_i, sel_i, stb_i, we_i,
    input  data_o, ack_o, err_o, rty_o
  );

  modport slave (
    input  addr_i, data_i, cyc_i, sel_i, stb_i, we_i,
    output data_o, ack_o, err_o, rty_o
  );
endinterface

// File: rtl/wb_uart_tx.sv
// Wishbone slave with byte FIFO and 8N1 serial transmitter; ack 1 cycle after request, tx_o falls 1 cycle after a push into an idle empty FIFO.
// Never stalls the bus: a push to a full FIFO is dropped and sets sticky overflow; WB_UART_PARITY_EN adds an even-parity bit.
module wb_uart_tx #(
  parameter int ADDR_WIDTH      = 31,
  parameter int DATA_WIDTH      = 32,
  parameter int CLK_DIV         = 868,
  parameter int FIFO_DEPTH_LOG2 = 3
) (
  input  logic          clk_i,
  input  logic          rst_i,
  wb_uart_tx_if.slave   bus,
  output logic          tx_o,
  output logic          irq_o
);
  localparam int DEPTH = 1 << FIFO_DEPTH_LOG2;
  localparam int CW    = FIFO_DEPTH_LOG2 + 1;
  localparam logic [FIFO_DEPTH_LOG2-1:0] PTR_ONE  = FIFO_DEPTH_LOG2'(1);
  localparam logic [CW-1:0]              CNT_ONE  = CW'(1);
  localparam logic [CW-1:0]              CNT_FULL = CW'(DEPTH);
  localparam logic [15:0]                DIV_LAST = 16'(CLK_DIV - 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
`ifdef WB_UART_PARITY_EN
  localparam logic [2:0] S_PARITY = 3'd3;
`endif
  localparam logic [2:0] S_STOP   = 3'd4;

  logic [7:0]                 mem_q [DEPTH];
  logic [FIFO_DEPTH_LOG2-1:0] wptr_q, rptr_q;
  logic [CW-1:0]              cnt_q, cnt_d;
  logic                       ovf_q, ovf_d;
  logic                       ack_q;
  logic [DATA_WIDTH-1:0]      dat_q;
  logic                       irq_q;
  logic [2:0]                 state_q, state_d;
  logic [15:0]                div_q, div_d;
  logic [2:0]                 bit_q, bit_d;
  logic [7:0]                 sh_q, sh_d;
  logic                       tx_q, tx_d;
`ifdef WB_UART_PARITY_EN
  logic                       par_q, par_d;
`endif

  logic                  req, push_req, st_rd, empty, full, pop, push, ovf_set, div_done;
  logic [1:0]            reg_sel;
  logic [DATA_WIDTH-1:0] status;
  logic                  unused_bits;

  assign reg_sel  = bus.addr_i[3:2];
  assign req      = bus.cyc_i & bus.stb_i & ~ack_q;
  assign push_req = req & bus.we_i & (reg_sel == 2'd0) & bus.sel_i[0];
  assign st_rd    = req & ~bus.we_i & (reg_sel == 2'd1);
  assign empty    = (cnt_q == '0);
  assign full     = (cnt_q == CNT_FULL);
  assign pop      = (state_q == S_IDLE) & ~empty;
  // A pop on the same edge frees a slot, so a push to a full FIFO is still accepted.
  assign push     = push_req & (~full | pop);
  assign ovf_set  = push_req & full & ~pop;
  assign div_done = (div_q == DIV_LAST);
  assign unused_bits = ^{bus.addr_i[ADDR_WIDTH-1:4], bus.addr_i[1:0],
                         bus.data_i[DATA_WIDTH-1:8], bus.sel_i[3:1]};

  always_comb begin
    status         = '0;
    status[0]      = (state_q != S_IDLE);
    status[1]      = full;
    status[2]      = empty;
    status[3]      = ovf_q;
`ifdef WB_UART_PARITY_EN
    status[4]      = 1'b1;
`endif
    status[8 +: CW] = cnt_q;
  end

  always_comb begin
    cnt_d = cnt_q;
    if (push && !pop)      cnt_d = cnt_q + CNT_ONE;
    else if (!push && pop) cnt_d = cnt_q - CNT_ONE;
    ovf_d = ovf_set ? 1'b1 : (st_rd ? 1'b0 : ovf_q);
  end

  always_comb begin
    state_d = state_q;
    div_d   = div_q + 16'd1;
    bit_d   = bit_q;
    sh_d    = sh_q;
    tx_d    = tx_q;
`ifdef WB_UART_PARITY_EN
    par_d   = par_q;
`endif
    case (state_q)
      S_IDLE: begin
        div_d = '0;
        if (pop) begin
          sh_d    = mem_q[rptr_q];
          tx_d    = 1'b0;
          state_d = S_START;
`ifdef WB_UART_PARITY_EN
          par_d   = ^mem_q[rptr_q];
`endif
        end
      end
      S_START: if (div_done) begin
        div_d   = '0;
        tx_d    = sh_q[0];
        sh_d    = sh_q >> 1;
        bit_d   = '0;
        state_d = S_DATA;
      end
      S_DATA: if (div_done) begin
        div_d = '0;
        if (bit_q == 3'd7) begin
`ifdef WB_UART_PARITY_EN
          tx_d    = par_q;
          state_d = S_PARITY;
`else
          tx_d    = 1'b1;
          state_d = S_STOP;
`endif
        end else begin
          bit_d = bit_q + 3'd1;
          tx_d  = sh_q[0];
          sh_d  = sh_q >> 1;
        end
      end
`ifdef WB_UART_PARITY_EN
      S_PARITY: if (div_done) begin
        div_d   = '0;
        tx_d    = 1'b1;
        state_d = S_STOP;
      end
`endif
      S_STOP: if (div_done) begin
        div_d   = '0;
        state_d = S_IDLE;
      end
      default: begin
        div_d   = '0;
        tx_d    = 1'b1;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (push) mem_q[wptr_q] <= bus.data_i[7:0];
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      ack_q   <= 1'b0;
      dat_q   <= '0;
      irq_q   <= 1'b1;
      state_q <= S_IDLE;
      div_q   <= '0;
      bit_q   <= '0;
      sh_q    <= '0;
      tx_q    <= 1'b1;
`ifdef WB_UART_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      if (push) wptr_q <= wptr_q + PTR_ONE;
      if (pop)  rptr_q <= rptr_q + PTR_ONE;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      ack_q   <= req;
      dat_q   <= st_rd ? status : '0;
      irq_q   <= empty & (state_q == S_IDLE);
      state_q <= state_d;
      div_q   <= div_d;
      bit_q   <= bit_d;
      sh_q    <= sh_d;
      tx_q    <= tx_d;
`ifdef WB_UART_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  assign bus.ack_o  = ack_q;
  assign bus.data_o = dat_q;
  assign bus.err_o  = 1'b0;
  assign bus.rty_o  = 1'b0;
  assign tx_o       = tx_q;
  assign irq_o      = irq_q;
endmodule

// File: tb/tb_wb_uart_tx.sv
// Bench for wb_uart_tx at CLK_DIV=4: register table, exact frame timing, overflow, reset abort, and random bursts
// decoded by an independent serial receiver and compared against a byte queue of accepted writes.
module tb_wb_uart_tx;
  localparam int DIV = 4;
`ifdef WB_UART_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  localparam int NBITS = 10 + PAR;
  localparam logic [31:0] ST_IDLE = 32'h4 | (32'(PAR) << 4);
  localparam logic [31:0] ST_FULL_OVF = 32'h80B | (32'(PAR) << 4);
  localparam logic [31:0] ST_FULL     = 32'h803 | (32'(PAR) << 4);

  typedef struct {
    logic        we;
    logic [1:0]  a;
    logic [31:0] wd;
    logic [3:0]  sel;
    logic [31:0] exp_rd;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic tx, irq;
  int total = 0;
  int bad = 0;
  logic [7:0] exp_q[$];
  logic [7:0] rx_q[$];
  logic [7:0] rxb;
  bit   rx_en = 1'b0;
  logic tx_at_ack;
  vec_t vecs[9];

  always #5 clk = ~clk;

  wb_uart_tx_if #(.ADDR_WIDTH(31), .DATA_WIDTH(32)) wb();

  wb_uart_tx #(
    .ADDR_WIDTH(31), .DATA_WIDTH(32), .CLK_DIV(DIV), .FIFO_DEPTH_LOG2(3)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .bus(wb),
    .tx_o(tx),
    .irq_o(irq)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic bus_acc(input logic we, input logic [1:0] a, input logic [31:0] wd,
                         input logic [3:0] sel, output logic [31:0] rd);
    logic [26:0] hi;
    logic got;
    hi = 27'($urandom);
    got = 1'b0;
    rd = '0;
    wb.addr_i = {hi, a, 2'b00};
    wb.data_i = wd;
    wb.sel_i  = sel;
    wb.we_i   = we;
    wb.cyc_i  = 1'b1;
    wb.stb_i  = 1'b1;
    for (int i = 0; i < 8 && !got; i++) begin
      @(posedge clk); #1;
      if (wb.ack_o) begin
        got = 1'b1;
        rd = wb.data_o;
        tx_at_ack = tx;
      end
    end
    wb.cyc_i = 1'b0;
    wb.stb_i = 1'b0;
    wb.we_i  = 1'b0;
    chk("ack_seen", {31'b0, got}, 32'd1);
    @(posedge clk); #1;
    chk("ack_one_cycle", {31'b0, wb.ack_o}, 32'd0);
    chk("data_o_cleared", wb.data_o, 32'd0);
  endtask

  task automatic wait_idle(input int max_cyc);
    logic got;
    got = 1'b0;
    for (int i = 0; i < max_cyc && !got; i++) begin
      @(posedge clk); #1;
      if (irq) got = 1'b1;
    end
    chk("idle_reached", {31'b0, got}, 32'd1);
  endtask

  // Drives one byte and checks every cycle of the resulting frame against the expected bit pattern.
  task automatic check_frame(input logic [7:0] b);
    logic [31:0] rd;
    logic [NBITS-1:0] bits;
`ifdef WB_UART_PARITY_EN
    bits = {1'b1, ^b, b, 1'b0};
`else
    bits = {1'b1, b, 1'b0};
`endif
    exp_q.push_back(b);
    bus_acc(1'b1, 2'd0, {24'h0, b}, 4'hF, rd);
    chk("tx_idle_at_ack", {31'b0, tx_at_ack}, 32'd1);
    for (int k = 0; k < NBITS; k++) begin
      for (int c = 0; c < DIV; c++) begin
        chk($sformatf("frame_%0h_bit%0d", b, k), {31'b0, tx}, {31'b0, bits[k]});
        @(posedge clk); #1;
      end
    end
    @(posedge clk); #1;
    chk("irq_after_frame", {31'b0, irq}, 32'd1);
    bus_acc(1'b0, 2'd1, 32'h0, 4'hF, rd);
    chk("status_after_frame", rd, ST_IDLE);
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (rx_en && tx === 1'b0) begin
        repeat (DIV / 2) @(negedge clk);
        chk("rx_start", {31'b0, tx}, 32'd0);
        for (int i = 0; i < 8; i++) begin
          repeat (DIV) @(negedge clk);
          rxb[i] = tx;
        end
`ifdef WB_UART_PARITY_EN
        repeat (DIV) @(negedge clk);
        chk("rx_parity", {31'b0, tx}, {31'b0, ^rxb});
`endif
        repeat (DIV) @(negedge clk);
        chk("rx_stop", {31'b0, tx}, 32'd1);
        rx_q.push_back(rxb);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] rd;
    logic [7:0]  b;
    int n, r, errs;

    vecs[0] = '{1'b0, 2'd1, 32'h0,        4'hF, ST_IDLE};
    vecs[1] = '{1'b0, 2'd0, 32'h0,        4'hF, 32'h0};
    vecs[2] = '{1'b0, 2'd2, 32'h0,        4'hF, 32'h0};
    vecs[3] = '{1'b0, 2'd3, 32'h0,        4'hF, 32'h0};
    vecs[4] = '{1'b1, 2'd0, 32'h5A,       4'hE, 32'h0};
    vecs[5] = '{1'b1, 2'd1, 32'hFFFFFFFF, 4'hF, 32'h0};
    vecs[6] = '{1'b1, 2'd2, 32'h000000C3, 4'hF, 32'h0};
    vecs[7] = '{1'b1, 2'd3, 32'h0000003C, 4'hF, 32'h0};
    vecs[8] = '{1'b1, 2'd0, 32'h00000011, 4'h0, 32'h0};

    wb.addr_i = '0; wb.data_i = '0; wb.sel_i = '0;
    wb.we_i = 1'b0; wb.cyc_i = 1'b0; wb.stb_i = 1'b0;

    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_tx", {31'b0, tx}, 32'd1);
    chk("rst_ack", {31'b0, wb.ack_o}, 32'd0);
    chk("rst_irq", {31'b0, irq}, 32'd1);
    chk("rst_data_o", wb.data_o, 32'd0);
    rst = 1'b0;
    bus_acc(1'b0, 2'd1, 32'h0, 4'hF, rd);
    chk("rst_status", rd, ST_IDLE);
    rx_en = 1'b1;

    for (int i = 0; i < 9; i++) begin
      bus_acc(vecs[i].we, vecs[i].a, vecs[i].wd, vecs[i].sel, rd);
      if (!vecs[i].we) chk($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rd);
      bus_acc(1'b0, 2'd1, 32'h0, 4'hF, rd);
      chk($sformatf("vec%0d_status", i), rd, ST_IDLE);
    end

    check_frame(8'hA5);
    check_frame(8'h07);

    for (int i = 0; i < 10; i++) begin
      b = 8'($urandom);
      if (i < 9) exp_q.push_back(b);
      bus_acc(1'b1, 2'd0, {24'h0, b}, 4'h1, rd);
    end
    bus_acc(1'b0, 2'd1, 32'h0, 4'hF, rd);
    chk("ovf_status1", rd, ST_FULL_OVF);
    bus_acc(1'b0, 2'd1, 32'h0, 4'hF, rd);
    chk("ovf_status2", rd, ST_FULL);
    wait_idle(9 * (NBITS * DIV + 1) + 40);

    for (int burst = 0; burst < 6; burst++) begin
      n = $urandom_range(1, 8);
      for (int j = 0; j < n; j++) begin
        r = $urandom_range(0, 9);
        b = 8'($urandom);
        if (r < 6) begin
          logic [3:0] s;
          s = 4'($urandom);
          if (s[0]) exp_q.push_back(b);
          bus_acc(1'b1, 2'd0, {24'($urandom), b}, s, rd);
        end else if (r < 8) begin
          bus_acc(1'b1, 2'($urandom_range(1, 3)), $urandom, 4'hF, rd);
        end else begin
          logic [1:0] ra;
          ra = (r == 8) ? 2'd0 : 2'($urandom_range(2, 3));
          bus_acc(1'b0, ra, 32'h0, 4'hF, rd);
          chk("rand_unmapped_read", rd, 32'd0);
        end
      end
      wait_idle(9 * (NBITS * DIV + 1) + 40);
    end

    repeat (4) @(posedge clk);
    #1;
    chk("rx_byte_count", rx_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++)
      chk($sformatf("rx_byte%0d", i), {24'h0, rx_q[i]}, {24'h0, exp_q[i]});

    rx_en = 1'b0;
    bus_acc(1'b1, 2'd0, 32'h30, 4'h1, rd);
    bus_acc(1'b1, 2'd0, 32'h55, 4'h1, rd);
    repeat (15) @(posedge clk);
    #1;
    chk("midframe_bit3", {31'b0, tx}, 32'd0);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("abort_tx", {31'b0, tx}, 32'd1);
    chk("abort_irq", {31'b0, irq}, 32'd1);
    rst = 1'b0;
    bus_acc(1'b0, 2'd1, 32'h0, 4'hF, rd);
    chk("abort_status", rd, ST_IDLE);
    errs = 0;
    for (int i = 0; i < 60; i++) begin
      @(posedge clk); #1;
      if (tx !== 1'b1) errs++;
    end
    chk("no_frame_after_reset", errs, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/wb_uart_tx.md
Name: wb_uart_tx

Overview:
- Wishbone B3 classic slave with a byte FIFO and an 8N1 serial transmitter.
- Attaches to slave port s1 of the 1-master/2-slave arbiter, which is selected by master address bit 24.
- The CPU writes bytes to TXDATA; the block queues them and shifts them out on tx_o.
- The CPU polls STATUS to read FIFO level and flags.

Parameters:
- ADDR_WIDTH, 31, slave address width; matches the arbiter's slave address output.
- DATA_WIDTH, 32, Wishbone data width.
- CLK_DIV, 868, clock cycles per serial bit; legal range 2..65535.
- FIFO_DEPTH_LOG2, 3, log2 of the TX FIFO depth; depth 8 by default.

Ports:
- clk_i  in  1  system clock; every register changes only on its rising edge.
- rst_i  in  1  synchronous reset, active high.
- addr_i  in  ADDR_WIDTH  word address; only bits [3:2] are decoded.
- data_i  in  DATA_WIDTH  write data.
- data_o  out  DATA_WIDTH  read data; registered.
- cyc_i  in  1  Wishbone cycle.
- sel_i  in  4  byte lane selects.
- stb_i  in  1  Wishbone strobe.
- we_i  in  1  write enable.
- ack_o  out  1  acknowledge; registered.
- err_o  out  1  error; tied to 0 unless WB_UART_PARITY_EN changes nothing here (always 0).
- rty_o  out  1  retry; tied to 0.
- tx_o  out  1  serial output; idle level is 1.
- irq_o  out  1  level interrupt; 1 while FIFO is empty and the shifter is idle.

Behaviour:
- Reset (rst_i=1 at a rising edge):
  - ack_o=0, data_o=0, tx_o=1, irq_o=1.
  - FIFO emptied; read and write pointers and count = 0.
  - Overflow flag = 0; state = IDLE; bit counter and divider counter = 0.
  - Reset mid-frame aborts the frame: tx_o returns to 1 on the next edge and the queued bytes are lost.
- Bus handshake:
  - Request = cyc_i & stb_i & ~ack_o.
  - On a request, ack_o=1 on the next edge for exactly one cycle.
  - Back-to-back accesses therefore ack at most every other cycle.
  - Every access is acked, including unmapped ones.
- Register map, decoded on addr_i[3:2]:
  - 0 TXDATA, write-only; reads return 0.
  - 1 STATUS, read-only; writes are acked and ignored.
  - 2,3 reserved; reads return 0, writes are ignored.
- TXDATA write:
  - Pushes data_i[7:0] on the same edge that raises ack_o.
  - Requires sel_i[0]=1; otherwise no push.
  - If the FIFO is full, the byte is dropped and the sticky overflow flag is set.
- STATUS read, data_o on the ack cycle:
  - [0] busy (state != IDLE).
  - [1] full.
  - [2] empty.
  - [3] overflow.
  - [8+:FIFO_DEPTH_LOG2+1] count.
  - All other bits 0.
  - The read clears overflow on the ack edge; an overflow occurring on that same edge wins (flag stays 1).
- data_o returns to 0 in the cycle after ack.
- FIFO:
  - Count is FIFO_DEPTH_LOG2+1 bits; pointers wrap modulo the depth.
  - A push and a pop on the same edge leave count unchanged.
  - A push to a full FIFO while a pop also occurs is accepted (no overflow).
- Transmitter state machine: IDLE, START, DATA, (PARITY), STOP.
  - IDLE with FIFO non-empty, at the edge: pop into an 8-bit shift register, tx_o<=0, go to START, divider counter cleared.
  - Each state holds its bit for CLK_DIV cycles.
  - START -> DATA: LSB first, 8 bits, bit counter 0..7.
  - DATA -> STOP: tx_o=1.
  - STOP -> IDLE.
  - Frame length is 10*CLK_DIV cycles.
  - If the FIFO is non-empty at the end of STOP, the next START begins on the following edge. This gives exactly one IDLE cycle between frames.
- Latency: tx_o falls 1 cycle after the ack of a write into an empty FIFO while IDLE.
- irq_o is registered and updates on the edge after its condition changes.

Optional Feature:
- Macro: WB_UART_PARITY_EN.
- When defined:
  - A PARITY state is inserted between DATA and STOP, transmitting the even parity of the byte (XOR of its 8 bits).
  - Frame length becomes 11*CLK_DIV cycles.
  - STATUS bit [4] reads 1.
- When undefined: 8N1, no PARITY state, STATUS[4]=0.

Test Plan:
- Reset: hold rst_i for 2 cycles -> tx_o=1, ack_o=0, irq_o=1; STATUS read returns 0x0000_0004.
- Single byte, CLK_DIV=4:
  - Write 0xA5 to TXDATA -> ack one cycle later; tx_o=0 one cycle after ack.
  - Then bits 1,0,1,0,0,1,0,1, each 4 cycles, then stop=1 for 4 cycles.
  - busy=0 and irq_o=1 after 40 cycles.
- Fill and overflow, depth 8, shifter stalled mid-frame:
  - Write 10 bytes quickly -> STATUS shows full=1 and overflow=1.
  - A second STATUS read shows overflow=0; exactly 9 bytes are transmitted (1 in the shifter + 8 queued).
- Sel and reserved:
  - Write to TXDATA with sel_i=4'b1110 -> acked, count stays 0.
  - Read addr[3:2]=3 -> acked, data_o=0.
- Reset mid-frame: assert rst_i during DATA bit 3 -> tx_o=1 on the next edge; FIFO count=0; no further frames.
- Parity (WB_UART_PARITY_EN defined): write 0x07 -> the parity bit after the data bits is 1 and the frame lasts 44 cycles at CLK_DIV=4.
